if_fetch_unit: RTL and testbench

Instruction-fetch stage driving the decode stage's instruction and PC+4 inputs, and consuming the decode stage's PC_next. Holds the architectural PC. Fetches through a variable-latency req/ready instruction-memory port. Inserts NOP bubbles while memory is busy or the fetched instruction is flushed. Holds a one-entry instruction buffer for hazard stalls.

---
 rtl/if_fetch_unit.sv | 120 ++++++++++++
 tb/tb_if_fetch_unit.sv | 189 ++++++++++++++++++
 2 files changed

// File: rtl/if_fetch_unit.sv
// rtl/if_fetch_unit.sv - instruction fetch stage with PC, wait-state handling and hazard hold buffer
//
// Purpose:
//   Holds the architectural PC, fetches through a variable-latency req/ready
//   instruction memory, presents instructions (or NOP bubbles) to decode, and
//   keeps a one-entry buffer so a stalled instruction stays on Ins_out.
//
// Ports:
//   clk, reset        clock; synchronous active-high reset
//   PC_next           next PC from decode (sampled only on advance / redirect)
//   Stall             load-use hazard: hold PC and current instruction
//   Flush             decode redirect: instruction currently in fetch is wrong-path
//   imem_req/addr     fetch request and address (addr = PC)
//   imem_ready/rdata  fetch completion strobe and instruction word
//   Ins_out/Ins_valid instruction presented to decode and its validity
//   PC_plus4_out      PC+4 of the presented slot
//   PC_out            current PC

module if_fetch_unit #(
  parameter logic [31:0] RESET_PC = 32'h80000000,
  parameter logic [31:0] NOP_INS  = 32'h00000000
) (
  input  logic        clk,
  input  logic        reset,
  input  logic [31:0] PC_next,
  input  logic        Stall,
  input  logic        Flush,
  output logic        imem_req,
  output logic [31:0] imem_addr,
  input  logic        imem_ready,
  input  logic [31:0] imem_rdata,
  output logic [31:0] Ins_out,
  output logic        Ins_valid,
  output logic [31:0] PC_plus4_out,
  output logic [31:0] PC_out
);

  typedef enum logic {
    S_REQ  = 1'b0,
    S_HOLD = 1'b1
  } state_t;

  state_t      r_state;
  logic [31:0] r_pc;
  logic [31:0] r_buf;
  logic        r_redirect_pending;
  logic [31:0] r_redirect_pc;

  // Fetched word is usable only if no redirect landed while it was in flight
  // and no redirect lands on the completion cycle itself.
  logic        w_accept;

  assign w_accept     = imem_ready && !r_redirect_pending && !Flush;
  assign imem_addr    = r_pc;
  assign PC_out       = r_pc;
  assign PC_plus4_out = r_pc + 32'd4;

  always_comb begin
    imem_req  = 1'b0;
    Ins_out   = NOP_INS;
    Ins_valid = 1'b0;
    if (!reset) begin
      case (r_state)
        S_REQ: begin
          imem_req = 1'b1;
          if (w_accept) begin
            Ins_out   = imem_rdata;
            Ins_valid = 1'b1;
          end
        end
        S_HOLD: begin
          Ins_out   = r_buf;
          Ins_valid = 1'b1;
        end
        default: ;
      endcase
    end
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      // Any outstanding request is abandoned; memory drops it on this reset too.
      r_pc               <= RESET_PC;
      r_state            <= S_REQ;
      r_buf              <= NOP_INS;
      r_redirect_pending <= 1'b0;
      r_redirect_pc      <= RESET_PC;
    end else begin
      case (r_state)
        S_REQ: begin
          if (!imem_ready) begin
            // Request cannot be cancelled: remember the redirect until it completes.
            if (Flush) begin
              r_redirect_pending <= 1'b1;
              r_redirect_pc      <= PC_next;
            end
          end else if (r_redirect_pending) begin
            r_pc               <= r_redirect_pc;
            r_redirect_pending <= 1'b0;
          end else if (Flush) begin
            r_pc <= PC_next;
          end else if (Stall) begin
            r_buf   <= imem_rdata;
            r_state <= S_HOLD;
          end else begin
            r_pc <= PC_next;
          end
        end
        S_HOLD: begin
          if (Flush || !Stall) begin
            r_pc    <= PC_next;
            r_state <= S_REQ;
          end
        end
        default: r_state <= S_REQ;
      endcase
    end
  end

endmodule

// File: tb/tb_if_fetch_unit.sv
// tb/tb_if_fetch_unit.sv - directed vector table plus randomized model check for if_fetch_unit

module tb_if_fetch_unit;

  logic        clk;
  logic        reset;
  logic [31:0] PC_next;
  logic        Stall;
  logic        Flush;
  logic        imem_req;
  logic [31:0] imem_addr;
  logic        imem_ready;
  logic [31:0] imem_rdata;
  logic [31:0] Ins_out;
  logic        Ins_valid;
  logic [31:0] PC_plus4_out;
  logic [31:0] PC_out;

  int checks = 0;
  int errors = 0;

  if_fetch_unit dut (
    .clk          (clk),
    .reset        (reset),
    .PC_next      (PC_next),
    .Stall        (Stall),
    .Flush        (Flush),
    .imem_req     (imem_req),
    .imem_addr    (imem_addr),
    .imem_ready   (imem_ready),
    .imem_rdata   (imem_rdata),
    .Ins_out      (Ins_out),
    .Ins_valid    (Ins_valid),
    .PC_plus4_out (PC_plus4_out),
    .PC_out       (PC_out)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  typedef struct {
    logic        rst;
    logic [31:0] pcn;
    logic        stall;
    logic        flush;
    logic        rdy;
    logic [31:0] rdata;
    logic        e_req;
    logic [31:0] e_addr;
    logic [31:0] e_ins;
    logic        e_valid;
  } vec_t;

  vec_t tbl[$];

  function automatic void add(input logic rst, input logic [31:0] pcn, input logic stall,
                              input logic flush, input logic rdy, input logic [31:0] rdata,
                              input logic e_req, input logic [31:0] e_addr,
                              input logic [31:0] e_ins, input logic e_valid);
    vec_t v;
    v.rst = rst; v.pcn = pcn; v.stall = stall; v.flush = flush; v.rdy = rdy;
    v.rdata = rdata; v.e_req = e_req; v.e_addr = e_addr; v.e_ins = e_ins; v.e_valid = e_valid;
    tbl.push_back(v);
  endfunction

  // Drive one cycle's inputs just after the falling edge, compare 1 time unit later.
  task automatic run_vec(input vec_t v, input string tag, input int idx);
    logic [31:0] exp_p4;
    @(negedge clk);
    reset      = v.rst;
    PC_next    = v.pcn;
    Stall      = v.stall;
    Flush      = v.flush;
    imem_ready = v.rdy;
    imem_rdata = v.rdata;
    #1;
    exp_p4 = v.e_addr + 32'd4;
    checks++;
    if (imem_req !== v.e_req || Ins_valid !== v.e_valid || Ins_out !== v.e_ins ||
        imem_addr !== v.e_addr || PC_out !== v.e_addr || PC_plus4_out !== exp_p4) begin
      errors++;
      $display("FAIL %s[%0d] got req=%b valid=%b ins=%h addr=%h pc=%h p4=%h expected req=%b valid=%b ins=%h addr=%h p4=%h",
               tag, idx, imem_req, Ins_valid, Ins_out, imem_addr, PC_out, PC_plus4_out,
               v.e_req, v.e_valid, v.e_ins, v.e_addr, exp_p4);
    end
  endtask

  // Reference state for the random phase, in architectural terms.
  logic [31:0] m_pc;
  logic        m_holding;
  logic [31:0] m_buf;
  logic        m_redir;
  logic [31:0] m_redir_pc;

  initial begin
    vec_t v;
    reset = 1'b1; PC_next = '0; Stall = 1'b0; Flush = 1'b0;
    imem_ready = 1'b0; imem_rdata = '0;
    @(negedge clk);
    @(negedge clk);

    //  rst pcn            st fl rdy rdata          req addr           ins            val
    add(1, 32'h0,          0, 0, 0, 32'h0,          0, 32'h80000000, 32'h0,          0); // reset cycle
    add(0, 32'h80000004,   0, 0, 1, 32'hA1A1A1A1,   1, 32'h80000000, 32'hA1A1A1A1,   1); // zero-wait
    add(0, 32'h80000008,   0, 0, 1, 32'hA2A2A2A2,   1, 32'h80000004, 32'hA2A2A2A2,   1);
    add(0, 32'h8000000C,   0, 0, 1, 32'hA3A3A3A3,   1, 32'h80000008, 32'hA3A3A3A3,   1);
    add(0, 32'h0,          0, 0, 0, 32'hDEAD0000,   1, 32'h8000000C, 32'h0,          0); // 2 wait states
    add(0, 32'h0,          0, 0, 0, 32'hDEAD0001,   1, 32'h8000000C, 32'h0,          0);
    add(0, 32'h80000010,   0, 0, 1, 32'hB1B1B1B1,   1, 32'h8000000C, 32'hB1B1B1B1,   1);
    add(0, 32'h0,          0, 0, 0, 32'h0,          1, 32'h80000010, 32'h0,          0);
    add(0, 32'h0,          0, 0, 0, 32'h0,          1, 32'h80000010, 32'h0,          0);
    add(0, 32'h80000014,   0, 0, 1, 32'hB2B2B2B2,   1, 32'h80000010, 32'hB2B2B2B2,   1);
    add(0, 32'h80000018,   1, 0, 1, 32'h8C880004,   1, 32'h80000014, 32'h8C880004,   1); // stall x3
    add(0, 32'h99999999,   1, 0, 0, 32'h11111111,   0, 32'h80000014, 32'h8C880004,   1);
    add(0, 32'h99999999,   1, 0, 1, 32'h22222222,   0, 32'h80000014, 32'h8C880004,   1);
    add(0, 32'h80000018,   0, 0, 0, 32'h0,          0, 32'h80000014, 32'h8C880004,   1); // release
    add(0, 32'h80000008,   0, 1, 0, 32'h0,          1, 32'h80000018, 32'h0,          0); // flush while waiting
    add(0, 32'h0,          0, 0, 1, 32'h12345678,   1, 32'h80000018, 32'h0,          0);
    add(0, 32'h0,          0, 0, 0, 32'h0,          1, 32'h80000008, 32'h0,          0);
    add(0, 32'h00400040,   1, 1, 1, 32'h55555555,   1, 32'h80000008, 32'h0,          0); // flush+stall on ready
    add(0, 32'h0,          0, 0, 0, 32'h0,          1, 32'h00400040, 32'h0,          0);
    add(0, 32'h77777777,   1, 0, 1, 32'hC1C1C1C1,   1, 32'h00400040, 32'hC1C1C1C1,   1); // enter hold
    add(0, 32'h00001000,   1, 1, 0, 32'h0,          0, 32'h00400040, 32'hC1C1C1C1,   1); // flush beats stall
    add(0, 32'h0,          0, 0, 0, 32'h0,          1, 32'h00001000, 32'h0,          0);
    add(0, 32'hFFFFFFFC,   0, 0, 1, 32'hD1D1D1D1,   1, 32'h00001000, 32'hD1D1D1D1,   1);
    add(0, 32'h00002000,   0, 1, 0, 32'h0,          1, 32'hFFFFFFFC, 32'h0,          0); // wrap, pending redirect
    add(1, 32'h0,          0, 0, 1, 32'hBAD0BAD0,   0, 32'hFFFFFFFC, 32'h0,          0); // reset mid-wait, late ready
    add(0, 32'h0,          0, 0, 0, 32'h0,          1, 32'h80000000, 32'h0,          0);
    add(0, 32'h80000004,   0, 0, 1, 32'hE1E1E1E1,   1, 32'h80000000, 32'hE1E1E1E1,   1); // pending was cleared
    add(0, 32'h0,          0, 0, 0, 32'h0,          1, 32'h80000004, 32'h0,          0);

    for (int i = 0; i < tbl.size(); i++) run_vec(tbl[i], "vec", i);

    // Random phase: start from reset so the reference state is known.
    v.rst = 1; v.pcn = '0; v.stall = 0; v.flush = 0; v.rdy = 0; v.rdata = '0;
    v.e_req = 0; v.e_addr = 32'h80000004; v.e_ins = 32'h0; v.e_valid = 0;
    run_vec(v, "rnd_reset", 0);
    m_pc = 32'h80000000; m_holding = 0; m_buf = '0; m_redir = 0; m_redir_pc = '0;

    for (int i = 0; i < 600; i++) begin
      v.rst   = ($urandom_range(0, 49) == 0);
      v.pcn   = {$urandom(), 2'b00} >> 0;
      v.pcn   = {v.pcn[31:2], 2'b00};
      v.stall = ($urandom_range(0, 3) == 0);
      v.flush = ($urandom_range(0, 6) == 0);
      v.rdy   = $urandom_range(0, 1);
      v.rdata = $urandom();

      v.e_addr = m_pc;
      if (v.rst) begin
        v.e_req = 0; v.e_ins = 32'h0; v.e_valid = 0;
      end else if (m_holding) begin
        v.e_req = 0; v.e_ins = m_buf; v.e_valid = 1;
      end else begin
        v.e_req = 1;
        if (v.rdy && !m_redir && !v.flush) begin
          v.e_ins = v.rdata; v.e_valid = 1;
        end else begin
          v.e_ins = 32'h0; v.e_valid = 0;
        end
      end
      run_vec(v, "rnd", i);

      if (v.rst) begin
        m_pc = 32'h80000000; m_holding = 0; m_buf = '0; m_redir = 0;
      end else if (m_holding) begin
        if (v.flush || !v.stall) begin
          m_pc = v.pcn; m_holding = 0;
        end
      end else if (!v.rdy) begin
        if (v.flush) begin
          m_redir = 1; m_redir_pc = v.pcn;
        end
      end else if (m_redir) begin
        m_pc = m_redir_pc; m_redir = 0;
      end else if (v.flush) begin
        m_pc = v.pcn;
      end else if (v.stall) begin
        m_buf = v.rdata; m_holding = 1;
      end else begin
        m_pc = v.pcn;
      end
    end

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
